// File: rtl/gap_quant_pkg.sv
// rtl/gap_quant_pkg.sv - shared types and constants for the GAP/requantise stage
// Purpose: FSM state encoding, 8-bit saturation limit and accumulator width helper.
// Ports: none (package).
// Optional macro GAP_ROUND_EN is consumed by relu_sat_u8, not here.
package gap_quant_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam int U8_MAX = 255;

  // Summing 2**shift samples of in_w bits needs shift extra bits of headroom.
  function automatic int acc_width(input int in_w, input int shift);
    return in_w + shift;
  endfunction

endpackage

// File: rtl/relu_sat_u8.sv
// rtl/relu_sat_u8.sv - averaging shift, ReLU and unsigned 8-bit saturation
// Purpose: combinational requantise q(x) of one signed accumulator.
// Ports:
//   x  in   ACC_W  signed accumulator value
//   y  out  8      unsigned activation
// Macro GAP_ROUND_EN: when defined, adds 2**(SHIFT-1) before the shift
// (round-half-up); otherwise the shift truncates toward minus infinity.
module relu_sat_u8
  import gap_quant_pkg::*;
#(
  parameter int ACC_W = 20,
  parameter int SHIFT = 4
) (
  input  logic signed [ACC_W-1:0] x,
  output logic        [7:0]       y
);

  // One extra bit so the rounding add can never wrap the most positive value.
  localparam int W = ACC_W + 1;

`ifdef GAP_ROUND_EN
  // SHIFT=0 means no averaging, so there is nothing to round.
  localparam logic signed [W-1:0] RND = (SHIFT > 0) ? W'((2 ** SHIFT) / 2) : '0;
`endif

  logic signed [W-1:0] xw;
  logic signed [W-1:0] v;

  always_comb begin
    xw = W'(x);
`ifdef GAP_ROUND_EN
    xw = xw + RND;
`endif
    v = xw >>> SHIFT;
    if (v[W-1]) begin
      y = '0;
    end else if (v > W'(U8_MAX)) begin
      y = 8'(U8_MAX);
    end else begin
      y = v[7:0];
    end
  end

endmodule

// File: rtl/gap_quant_unit.sv
// rtl/gap_quant_unit.sv - global-average-pool and requantise stage feeding the FC unit
// Purpose: accumulate NPIX x C channel-interleaved signed samples per channel,
// then emit C requantised unsigned 8-bit activations, one per cycle.
// Ports:
//   clk         in   1     clock, rising edge
//   rst         in   1     synchronous active-high reset
//   in_data     in   IN_W  signed conv sample
//   in_valid    in   1     sample present
//   in_ready    out  1     block can accept (low while streaming results)
//   out_data    out  8     activation, channel order 0..C-1
//   out_valid   out  1     out_data valid, no backpressure
//   frame_done  out  1     pulse with channel C-1's output
// Macro GAP_ROUND_EN selects round-half-up requantisation (see relu_sat_u8).
module gap_quant_unit
  import gap_quant_pkg::*;
#(
  parameter int C     = 32,
  parameter int NPIX  = 16,
  parameter int SHIFT = 4,
  parameter int IN_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN_W-1:0] in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [7:0]      out_data,
  output logic            out_valid,
  output logic            frame_done
);

  localparam int ACC_W = acc_width(IN_W, SHIFT);
  localparam int CW    = (C > 1) ? $clog2(C) : 1;
  localparam int PW    = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CW-1:0] CH_LAST  = CW'(C - 1);
  localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);

  state_t state;
  state_t state_nxt;

  logic [CW-1:0] ch_cnt;
  logic [CW-1:0] out_cnt;
  logic [PW-1:0] pix_cnt;

  logic signed [ACC_W-1:0] acc [C];
  logic signed [ACC_W-1:0] sample_ext;

  logic       accept;
  logic       last_sample;
  logic [7:0] q_out;

  assign sample_ext = ACC_W'($signed(in_data));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_ACC: begin
        if (accept) begin
          state_nxt = last_sample ? S_OUT : S_ACC;
        end
      end
      S_OUT: begin
        if (out_cnt == CH_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs
  always_comb begin
    in_ready    = (state != S_OUT);
    accept      = in_valid && in_ready;
    last_sample = (ch_cnt == CH_LAST) && (pix_cnt == PIX_LAST);
  end

  // Counters and registered output stream
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt     <= '0;
      pix_cnt    <= '0;
      out_cnt    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (accept) begin
        if (ch_cnt == CH_LAST) begin
          ch_cnt  <= '0;
          pix_cnt <= last_sample ? '0 : pix_cnt + PW'(1);
        end else begin
          ch_cnt <= ch_cnt + CW'(1);
        end
        if (last_sample) begin
          out_cnt <= '0;
        end
      end

      if (state == S_OUT) begin
        out_valid  <= 1'b1;
        out_data   <= q_out;
        frame_done <= (out_cnt == CH_LAST);
        out_cnt    <= (out_cnt == CH_LAST) ? '0 : out_cnt + CW'(1);
      end else begin
        out_valid  <= 1'b0;
        frame_done <= 1'b0;
      end
    end
  end

  // Pixel 0 overwrites, so a new frame never needs a clear pass over acc.
  always_ff @(posedge clk) begin
    if (accept) begin
      acc[ch_cnt] <= (pix_cnt == '0) ? sample_ext : acc[ch_cnt] + sample_ext;
    end
  end

  relu_sat_u8 #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_relu_sat (
    .x (acc[out_cnt]),
    .y (q_out)
  );

endmodule

// File: tb/tb_gap_quant_unit.sv
// tb/tb_gap_quant_unit.sv - randomized self-checking bench for gap_quant_unit
module tb_gap_quant_unit;

  localparam int C     = 32;
  localparam int NPIX  = 16;
  localparam int SHIFT = 4;
  localparam int IN_W  = 16;
  localparam int TOTAL = C * NPIX;

  logic            clk = 1'b0;
  logic            rst;
  logic [IN_W-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [7:0]      out_data;
  logic            out_valid;
  logic            frame_done;

  int n_vec = 0;
  int n_bad = 0;

  int         frame [NPIX][C];
  logic [7:0] got_q [$];
  logic       fd_q [$];
  logic [7:0] prev_out [C];

  always #5 clk = ~clk;

  gap_quant_unit #(
    .C     (C),
    .NPIX  (NPIX),
    .SHIFT (SHIFT),
    .IN_W  (IN_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .frame_done (frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output monitor, sampled 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    if (out_valid === 1'b1) begin
      got_q.push_back(out_data);
      fd_q.push_back(frame_done);
    end else if (frame_done === 1'b1) begin
      chk("frame_done_without_valid", 1, 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // Reference requantiser: mean by floor shift (or round-half-up), clamp to 0..255.
  function automatic int q_ref(input int sum);
    int v;
`ifdef GAP_ROUND_EN
    v = (sum + (1 << SHIFT) / 2) >>> SHIFT;
`else
    v = sum >>> SHIFT;
`endif
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic fill_random(input int span);
    logic signed [IN_W-1:0] s;
    for (int p = 0; p < NPIX; p++)
      for (int c = 0; c < C; c++) begin
        if (span == 0) begin
          s = IN_W'($urandom);
          frame[p][c] = s;
        end else begin
          frame[p][c] = int'($urandom_range(2 * span)) - span;
        end
      end
  endtask

  task automatic check_frame();
    int sum;
    chk("n_out", got_q.size(), C);
    for (int c = 0; c < C; c++) begin
      sum = 0;
      for (int p = 0; p < NPIX; p++) sum += frame[p][c];
      if (c < got_q.size()) begin
        chk("out_data", got_q[c], q_ref(sum));
        chk("frame_done", fd_q[c], (c == C - 1) ? 1 : 0);
      end
    end
  endtask

  // Offers n samples of frame[] in order, dropping in_valid with probability gap_pct%.
  // With hold set, keeps in_valid high (value 7) through the output phase.
  task automatic drive_frame(input int n, input int gap_pct, input bit hold);
    int idx;
    int cyc;
    int hold_n;
    bit acc_ok;
    idx = 0;
    cyc = 0;
    got_q.delete();
    fd_q.delete();
    while (idx < n && cyc < 20 * TOTAL) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = IN_W'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = IN_W'(frame[idx / C][idx % C]);
      end
      acc_ok = in_valid && in_ready;
      @(posedge clk);
      #2;
      if (acc_ok) idx++;
      cyc++;
    end
    chk("accepted", idx, n);
    if (hold) begin
      in_valid = 1'b1;
      in_data  = IN_W'(7);
      hold_n   = 0;
      while (frame_done !== 1'b1 && hold_n < C + 4) begin
        chk("ready_low_in_out", in_ready, 0);
        @(posedge clk);
        #2;
        hold_n++;
      end
      chk("latency", hold_n, C);
      chk("ready_back", in_ready, 1);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // Directed channels plus random filler
    fill_random(1000);
    for (int p = 0; p < NPIX; p++) begin
      frame[p][0] = 16;
      frame[p][1] = -5;
      frame[p][2] = 1000;
      frame[p][3] = 32767;
      frame[p][4] = (p == 0) ? 8 : 0;
      frame[p][5] = (p == 0) ? -8 : 0;
    end
    drive_frame(TOTAL, 0, 1'b1);
    check_frame();
    if (got_q.size() == C) begin
      chk("avg_ch0", got_q[0], 16);
      chk("relu_ch1", got_q[1], 0);
      chk("sat_ch2", got_q[2], 255);
      chk("sat_nowrap_ch3", got_q[3], 255);
`ifdef GAP_ROUND_EN
      chk("round_ch4", got_q[4], 1);
`else
      chk("round_ch4", got_q[4], 0);
`endif
      chk("round_neg_ch5", got_q[5], 0);
      for (int i = 0; i < C; i++) prev_out[i] = got_q[i];
    end

    // Same frame with random gaps, started back-to-back
    drive_frame(TOTAL, 30, 1'b1);
    check_frame();
    if (got_q.size() == C)
      for (int i = 0; i < C; i++) chk("gap_equals_nogap", got_q[i], prev_out[i]);

    // Back-to-back frame: pixel-0 overwrite must discard the previous frame
    fill_random(500);
    for (int p = 0; p < NPIX; p++) frame[p][0] = 32;
    drive_frame(TOTAL, 0, 1'b1);
    check_frame();
    if (got_q.size() == C) chk("b2b_ch0", got_q[0], 32);

    // Full-range random frames
    for (int k = 0; k < 3; k++) begin
      fill_random(0);
      drive_frame(TOTAL, 20, 1'b1);
      check_frame();
    end

    // Reset mid-frame, then a fresh frame
    fill_random(0);
    drive_frame(100, 10, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    fill_random(2000);
    drive_frame(TOTAL, 15, 1'b1);
    check_frame();

    // Reset during the output phase
    fill_random(0);
    drive_frame(TOTAL, 0, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    chk("outrst_pre_valid", out_valid, 1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    chk("outrst_out_valid", out_valid, 0);
    chk("outrst_frame_done", frame_done, 0);
    chk("outrst_in_ready", in_ready, 1);
    fill_random(0);
    drive_frame(TOTAL, 10, 1'b1);
    check_frame();

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gap_quant_unit.md
Name: gap_quant_unit

Overview:
- Global-average-pool and requantise stage that sits directly upstream of the FC/argmax unit.
- Consumes the last conv layer's signed per-channel results, NPIX pixels × C channels, channel-interleaved within each pixel.
- Averages each channel by arithmetic right shift, applies ReLU and saturates to an unsigned 8-bit activation.
- Streams the C activations one per cycle on a valid-only interface, matching the FC unit's input contract.

Parameters:
- C, 32, channel count; equals the FC unit's input dimension.
- NPIX, 16, spatial positions per frame (4×4).
- SHIFT, 4, averaging shift; must equal log2(NPIX).
- IN_W, 16, signed input width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  IN_W  signed conv output sample.
- in_valid  input  1  sample present.
- in_ready  output  1  block can accept; a sample transfers when in_valid && in_ready.
- out_data  output  8  unsigned activation, channel order 0..C-1.
- out_valid  output  1  out_data is valid this cycle; there is no backpressure.
- frame_done  output  1  one-cycle pulse together with channel C-1's output.

Behaviour:
- Single clock domain. Reset is synchronous and active-high: all state is updated only on clk rising edges, and rst=1 at an edge resets it.
- Reset values: state=S_IDLE, ch_cnt=0, pix_cnt=0, out_cnt=0, out_data=0, out_valid=0, frame_done=0. Accumulators need no reset.
- Accumulators: acc[C], width ACC_W = IN_W+SHIFT, signed. Input is sign-extended before use.
- in_ready is combinational: in_ready = (state != S_OUT).
- in_valid while in_ready=0 is ignored; no counter or acc change.
- Gaps in in_valid are allowed at any point; counters advance only on accepted samples.
- Accept rule for a sample on channel ch_cnt:
  - pix_cnt==0: acc[ch_cnt] <= sample. This overwrites, so no clear cycle is needed.
  - otherwise: acc[ch_cnt] <= acc[ch_cnt] + sample.
- Counter rule: ch_cnt increments and wraps at C-1 → 0. On that wrap, pix_cnt increments.
- State machine:
  - S_IDLE → S_ACC on the first accepted sample.
  - S_ACC → S_OUT on the accepted sample with pix_cnt==NPIX-1 and ch_cnt==C-1. On that edge ch_cnt, pix_cnt and out_cnt all become 0.
  - S_OUT → S_IDLE at the edge where out_cnt==C-1.
- In S_OUT, each edge:
  - out_valid <= 1.
  - out_data <= q(acc[out_cnt]).
  - frame_done <= (out_cnt==C-1).
  - out_cnt increments.
- In S_IDLE/S_ACC: out_valid <= 0, frame_done <= 0. out_data holds its last value.
- Latency: if the last input is accepted at edge E, out_valid is high after edges E+1..E+C, exactly C consecutive cycles. in_ready rises after edge E+C.
- q(x), the requantise function:
  - v = x >>> SHIFT, arithmetic shift.
  - If v<0: 0. Else if v>255: 255. Else v[7:0].
- Overflow: none possible, since ACC_W covers NPIX·(2^(IN_W-1)).
- Reset mid-frame or mid-output: outputs drop on that edge and the partial frame is discarded. The next accepted sample is treated as pixel 0, channel 0.

Optional Feature:
- Macro GAP_ROUND_EN.
- Defined: q uses v = (x + 2^(SHIFT-1)) >>> SHIFT, i.e. round-half-up. Add a guard so SHIFT=0 adds nothing; the widened add must not wrap.
- Undefined: truncating arithmetic shift (floor).
- Handshake timing is identical either way.

Decomposition:
- Package gap_quant_pkg holds:
  - state encoding S_IDLE/S_ACC/S_OUT;
  - U8_MAX=255;
  - ACC_W function of IN_W and SHIFT.
- Sub-module relu_sat_u8: combinational shift (+ optional round), ReLU and saturation from ACC_W to 8 bits. It is instantiated once on acc[out_cnt].
- Counters and FSM stay in the top module.

Test Plan:
- Averaging: ch0 = 16 at all 16 pixels, other channels 0 → out_data stream 16,0,0,…; exactly 32 out_valid cycles; frame_done on the 32nd.
- ReLU and saturation: ch1 = -5 everywhere → 0. ch2 = 1000 everywhere → 255. ch3 = 32767 everywhere → 255, with no wrap.
- Rounding: ch4 = 8 at pixel 0, else 0 → 0 without GAP_ROUND_EN, 1 with it. ch5 = -8 at pixel 0 → 0 in both builds.
- Flow control: in_valid held high through S_OUT with value 7 → those samples are not accepted (in_ready=0). A random in_valid gap pattern in S_ACC → same outputs as the gap-free run.
- Back-to-back frames: a second frame with ch0 = 32 everywhere, started the cycle in_ready rises → outputs 32 for ch0. This checks that the pixel-0 overwrite clears the prior frame.
- Reset mid-frame: rst=1 after 100 accepted samples, then a full fresh frame → outputs depend only on the fresh frame. Reset during S_OUT → out_valid=0 on the next edge.
